cronometro_contador: RTL and testbench
======================================

# cronometro_contador

Stopwatch time-keeping core that consumes the one-cycle 1 Hz `tick` pulse from the clock divider and counts elapsed time in BCD minutes:seconds. Start/stop and clear pulses, already debounced and edge-detected upstream, drive a small run-control state machine. The BCD outputs feed the 7-segment decoder stage directly.

## Interface
Parameters:
- `MAX_MINUTES`, default 59: highest minute value reached before saturation; legal range 1..99.

Ports:
- `clk` input 1: system clock (50 MHz board clock).
- `rst_n` input 1: reset, asynchronous, active-low.
- `tick` input 1: one-cycle count enable, one per second.
- `start_stop` input 1: one-cycle pulse that toggles run/pause.
- `clear` input 1: one-cycle pulse that zeroes the count.
- `lap` input 1: one-cycle pulse that toggles display hold. Only active with the lap macro.
- `seg_u` output 4: seconds units, BCD 0–9.
- `seg_d` output 4: seconds tens, BCD 0–5.
- `min_u` output 4: minutes units, BCD 0–9.
- `min_d` output 4: minutes tens, BCD 0–9.
- `running` output 1: 1 while in RUN.
- `overflow` output 1: sticky; 1 while in FULL.
- `lap_active` output 1: 1 while the display is frozen.

## Operation
States:
- IDLE: count is 00:00. Reset lands here.
- RUN: counting.
- PAUSE: count held.
- FULL: saturated at MAX_MINUTES:59.

Transitions:
- IDLE, start_stop → RUN.
- RUN, start_stop → PAUSE.
- PAUSE, start_stop → RUN.
- RUN, tick at MAX_MINUTES:59 → FULL. Digits hold at MAX_MINUTES:59.
- Any state, clear → IDLE. Count becomes 00:00.
- FULL, start_stop → ignored.

Count rules:
- Increment happens only when the current state is RUN and `tick`=1.
- Seconds units wrap 9→0 and carry into seconds tens.
- Seconds tens wrap 5→0 and carry into minutes.
- Minutes count as a two-digit BCD pair 00..MAX_MINUTES.
- No binary-to-BCD conversion; each digit is its own modulo counter.

Priority when events coincide in one cycle:
- `clear` beats `start_stop`, `lap` and `tick`.
- `tick` is evaluated against the pre-edge state:
  - start_stop with tick in IDLE or PAUSE: no increment that cycle.
  - start_stop with tick in RUN: the tick is counted, then the state moves to PAUSE.

## Timing
- All outputs are registered.
- Digits change on the clock edge where `tick`=1 is sampled; the new value is visible the next cycle (1-cycle latency).
- `running` and `overflow` update on the same edge as the state.
- Reset values: all digits 0, `running`=0, `overflow`=0, `lap_active`=0, state IDLE.
- Asserting `rst_n` mid-count clears everything immediately, regardless of `clk`.
- Inputs are single-cycle pulses. A pulse held high for N cycles acts as N pulses; upstream guarantees single cycles.

## Configuration
Macro `CRONOMETRO_LAP_EN`.

Defined:
- A `lap` pulse while in RUN, with hold off, freezes the output digits and sets `lap_active`=1. The internal count keeps running.
- A second `lap` pulse releases the hold; outputs track the live count again from the next cycle.
- `lap` in IDLE, PAUSE or FULL releases the hold if it is set; otherwise it is ignored.
- `clear` releases the hold.
- A `start_stop` to PAUSE keeps the hold.

Undefined:
- The `lap` port is present but ignored.
- `lap_active` is tied 0.
- Outputs are the live count.

## Structure
- Package `cronometro_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/FULL);
  - the `bcd_t` 4-bit typedef;
  - constants `SEG_U_MAX`=9 and `SEG_D_MAX`=5.
- Sub-module `cronometro_bcd_digit` is a single BCD digit counter:
  - parameter `MODULO`;
  - inputs: `inc`, `clr`;
  - outputs: `value`, `carry` (asserted when `inc` at MODULO−1);
  - shares `clk`/`rst_n`.
- The top instantiates four digits plus the FSM. Minutes-tens wraps at 10.
- MAX_MINUTES saturation is decided by the top comparing the full `{min_d,min_u}` pair against MAX_MINUTES and `{seg_d,seg_u}` against 59.

## Test plan
- Reset, then start_stop, then 61 ticks → 01:01, `running`=1; start_stop → `running`=0, 10 further ticks leave 01:01.
- Run from 00:09, one tick → 00:10. From 00:59, one tick → 01:00. From 09:59, one tick → 10:00.
- MAX_MINUTES=2, run to 02:59, one tick → holds 02:59, `overflow`=1, `running`=0; start_stop ignored; clear → 00:00, `overflow`=0.
- At 00:05 in RUN:
  - clear+start_stop+tick in one cycle → 00:00, IDLE.
  - start_stop+tick in the next cycle → RUN, still 00:00.
- With `CRONOMETRO_LAP_EN`: at 00:03 in RUN, lap → outputs hold 00:03, `lap_active`=1; 5 ticks, then lap → outputs 00:08 the next cycle.
- `rst_n` dropped asynchronously mid-cycle at 12:34 in RUN → all outputs 0 before the next `clk` edge.

Source files
------------

// File: rtl/cronometro_pkg.sv
// Shared types and constants for the cronometro stopwatch core.
package cronometro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int SEG_U_MAX = 9;
  localparam int SEG_D_MAX = 5;

  // Two-digit BCD encoding of a 0..99 integer, {tens, units}.
  function automatic logic [7:0] to_bcd2(input int v);
    bcd_t tens;
    bcd_t units;
    tens  = bcd_t'(v / 10);
    units = bcd_t'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/cronometro_bcd_digit.sv
// Single BCD digit modulo counter; value registered, carry is combinational on inc at MODULO-1.
// clr has priority over inc.
module cronometro_bcd_digit
  import cronometro_pkg::*;
#(
  parameter int MODULO = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  bcd_t value_q;
  bcd_t value_d;

  assign carry = inc && (value_q == bcd_t'(MODULO - 1));

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = carry ? '0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/cronometro_contador.sv
// Stopwatch core: BCD mm:ss counting on 1 Hz tick with run/pause/saturate control, 1-cycle latency.
// Optional display hold (lap) enabled by macro CRONOMETRO_LAP_EN.
module cronometro_contador
  import cronometro_pkg::*;
#(
  parameter int MAX_MINUTES = 59
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] seg_u,
  output logic [3:0] seg_d,
  output logic [3:0] min_u,
  output logic [3:0] min_d,
  output logic       running,
  output logic       overflow,
  output logic       lap_active
);

  localparam logic [7:0] MAX_BCD = to_bcd2(MAX_MINUTES);

  state_t state_q, state_d;
  logic   running_q, running_d;
  logic   overflow_q, overflow_d;

  bcd_t su_v, sd_v, mu_v, md_v;
  logic su_c, sd_c, mu_c, md_c;
  logic at_max;
  logic inc_en;
  logic [15:0] live;

  assign live   = {md_v, mu_v, sd_v, su_v};
  assign at_max = (live[15:8] == MAX_BCD) && (live[7:0] == 8'h59);
  assign inc_en = (state_q == ST_RUN) && tick && !at_max && !clear;

  cronometro_bcd_digit #(.MODULO(SEG_U_MAX + 1)) u_seg_u (
    .clk(clk), .rst_n(rst_n), .inc(inc_en), .clr(clear), .value(su_v), .carry(su_c)
  );
  cronometro_bcd_digit #(.MODULO(SEG_D_MAX + 1)) u_seg_d (
    .clk(clk), .rst_n(rst_n), .inc(su_c), .clr(clear), .value(sd_v), .carry(sd_c)
  );
  cronometro_bcd_digit #(.MODULO(10)) u_min_u (
    .clk(clk), .rst_n(rst_n), .inc(sd_c), .clr(clear), .value(mu_v), .carry(mu_c)
  );
  // Minutes tens never carries out since MAX_MINUTES <= 99 saturates first.
  cronometro_bcd_digit #(.MODULO(10)) u_min_d (
    .clk(clk), .rst_n(rst_n), .inc(mu_c), .clr(clear), .value(md_v), .carry(md_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      running_q  <= running_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_stop) state_d = ST_RUN;
        ST_RUN: begin
          if (tick && at_max) state_d = ST_FULL;
          else if (start_stop) state_d = ST_PAUSE;
        end
        ST_PAUSE: if (start_stop) state_d = ST_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    running_d  = (state_d == ST_RUN);
    overflow_d = (state_d == ST_FULL);
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef CRONOMETRO_LAP_EN
  logic        hold_q, hold_d;
  logic [15:0] frz_q, frz_d;
  logic [15:0] disp;

  always_comb begin
    hold_d = hold_q;
    frz_d  = frz_q;
    if (clear) begin
      hold_d = 1'b0;
    end else if (lap) begin
      if ((state_q == ST_RUN) && !hold_q) begin
        hold_d = 1'b1;
        frz_d  = live;
      end else begin
        hold_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      frz_q  <= '0;
    end else begin
      hold_q <= hold_d;
      frz_q  <= frz_d;
    end
  end

  assign disp       = hold_q ? frz_q : live;
  assign lap_active = hold_q;
`else
  logic [15:0] disp;
  logic        unused_lap;

  assign unused_lap = lap ^ md_c;
  assign disp       = live;
  assign lap_active = 1'b0;
`endif

  assign {min_d, min_u, seg_d, seg_u} = disp;

endmodule

// File: tb/tb_cronometro_contador.sv
// Scoreboard bench: two instances (MAX_MINUTES 59 and 2) share stimulus and are checked against a seconds-based model.
module tb_cronometro_contador;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;

  logic [3:0] a_su, a_sd, a_mu, a_md, b_su, b_sd, b_mu, b_md;
  logic a_run, a_ovf, a_lap, b_run, b_ovf, b_lap;

  int n_cmp = 0;
  int n_err = 0;
  string phase = "reset";

  logic [37:0] sb_q[$];

  int m_st[2];
  int m_cnt[2];
  int m_frz[2];
  bit m_hold[2];
  int m_max[2] = '{59, 2};

  always #5 clk = ~clk;

  cronometro_contador #(.MAX_MINUTES(59)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .seg_u(a_su), .seg_d(a_sd), .min_u(a_mu), .min_d(a_md),
    .running(a_run), .overflow(a_ovf), .lap_active(a_lap)
  );

  cronometro_contador #(.MAX_MINUTES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .seg_u(b_su), .seg_d(b_sd), .min_u(b_mu), .min_d(b_md),
    .running(b_run), .overflow(b_ovf), .lap_active(b_lap)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] m_out(input int i);
    int c, sec, mn;
    logic [3:0] d3, d2, d1, d0;
    c   = m_hold[i] ? m_frz[i] : m_cnt[i];
    sec = c % 60;
    mn  = c / 60;
    d3  = 4'(mn / 10);
    d2  = 4'(mn % 10);
    d1  = 4'(sec / 10);
    d0  = 4'(sec % 10);
    return {d3, d2, d1, d0, m_st[i] == 1, m_st[i] == 3, m_hold[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_frz[i] = 0; m_hold[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ss, input bit clr, input bit tk, input bit lp);
    int nst;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_st[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0;
      end else begin
        nst = m_st[i];
`ifdef CRONOMETRO_LAP_EN
        if (lp) begin
          if (m_st[i] == 1 && !m_hold[i]) begin
            m_hold[i] = 1'b1;
            m_frz[i]  = m_cnt[i];
          end else begin
            m_hold[i] = 1'b0;
          end
        end
`else
        if (lp) m_hold[i] = 1'b0;
`endif
        if (m_st[i] == 1 && tk) begin
          if (m_cnt[i] == m_max[i] * 60 + 59) nst = 3;
          else m_cnt[i]++;
        end
        if (ss && nst != 3) begin
          case (m_st[i])
            0: nst = 1;
            1: nst = 2;
            2: nst = 1;
            default: nst = m_st[i];
          endcase
        end
        m_st[i] = nst;
      end
    end
  endtask

  task automatic push_exp();
    sb_q.push_back({m_out(0), m_out(1)});
  endtask

  task automatic pop_cmp();
    logic [37:0] e;
    if (sb_q.size() == 0) begin
      check({phase, " sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check({phase, " dut_a"}, {13'd0, a_md, a_mu, a_sd, a_su, a_run, a_ovf, a_lap}, {13'd0, e[37:19]});
      check({phase, " dut_b"}, {13'd0, b_md, b_mu, b_sd, b_su, b_run, b_ovf, b_lap}, {13'd0, e[18:0]});
    end
  endtask

  task automatic step(input bit ss, input bit clr, input bit tk, input bit lp);
    start_stop = ss; clear = clr; tick = tk; lap = lp;
    model_step(ss, clr, tk, lp);
    push_exp();
    @(posedge clk);
    #1;
    start_stop = 1'b0; clear = 1'b0; tick = 1'b0; lap = 1'b0;
    @(negedge clk);
    pop_cmp();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    push_exp();
    pop_cmp();
    @(negedge clk);
    rst_n = 1'b1;

    phase = "run61";
    step(1, 0, 0, 0);
    ticks(61);
    phase = "pause";
    step(1, 0, 0, 0);
    ticks(10);

    phase = "carry_sat";
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ticks(600);
    step(1, 0, 0, 0);
    ticks(3);
    step(0, 1, 0, 0);

    phase = "coincide";
    step(1, 0, 0, 0);
    ticks(5);
    step(1, 1, 1, 0);
    step(1, 0, 1, 0);
    ticks(2);

    phase = "lap";
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ticks(3);
    step(0, 0, 0, 1);
    ticks(5);
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    step(1, 0, 1, 0);
    ticks(2);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);

    phase = "async_rst";
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ticks(754);
    #2;
    rst_n = 1'b0;
    model_reset();
    push_exp();
    #1;
    pop_cmp();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    pop_cmp();
    phase = "post_rst";
    step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
